// File: rtl/csr_counters.sv
// csr_counters: mcycle/minstret/mhpm counter bank, inhibit and enable CSRs.
// Combinational read/hit/fault path, registered counter and CSR state.
//
// Ports:
//   clock, reset         sole clock, synchronous active-high reset
//   csr_op, trap         CSR operation; trap blocks all writes
//   addr, wr_data        CSR address and source operand
//   privilege_mode       current privilege (U=0, S=1, M=3)
//   instret_pulse        one instruction retires this cycle
//   hpm_event            per-cycle event strobes
//   mtime                platform timer, read via time/timeh
//   rd_data              read value, 0 when addr_hit is low
//   addr_hit             addr belongs to this block
//   access_fault         illegal access, valid when addr_hit is high
package csr_counters_pkg;
  typedef enum logic [1:0] {
    CsrRd = 2'd0,
    CsrRW = 2'd1,
    CsrRS = 2'd2,
    CsrRC = 2'd3
  } cs_op_t;
endpackage

module csr_counters
  import csr_counters_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int HPM_COUNTERS = 4,
  parameter int HPM_WIDTH    = 40,
  parameter int NUM_EVENTS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  cs_op_t                csr_op,
  input  logic                  trap,
  input  logic [11:0]           addr,
  input  logic [DATA_SIZE-1:0]  wr_data,
  input  logic [1:0]            privilege_mode,
  input  logic                  instret_pulse,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  input  logic [63:0]           mtime,
  output logic [DATA_SIZE-1:0]  rd_data,
  output logic                  addr_hit,
  output logic                  access_fault
);

  localparam int EW = $clog2(NUM_EVENTS + 1);
  localparam int NH = (HPM_COUNTERS > 0) ? HPM_COUNTERS : 1;
  localparam bit RV32 = (DATA_SIZE == 32);
  localparam logic [63:0] HPM_M64 =
    ((64'd1 << HPM_COUNTERS) - 64'd1) << 3;
  localparam logic [31:0] INH_MASK = HPM_M64[31:0] | 32'h5;
  localparam logic [31:0] EN_MASK  = HPM_M64[31:0] | 32'h7;

  logic [63:0]          mcycle_q, mcycle_d;
  logic [63:0]          minstret_q, minstret_d;
  logic [HPM_WIDTH-1:0] hpm_q [NH];
  logic [HPM_WIDTH-1:0] hpm_d [NH];
  logic [EW-1:0]        evt_q [NH];
  logic [EW-1:0]        evt_d [NH];
  logic [31:0]          inh_q, inh_d;
  logic [31:0]          mcen_q, mcen_d;
  logic [31:0]          scen_q, scen_d;

  logic [4:0] idx;
  logic [6:0] blk;
  logic is_inh, is_evt, is_mcen, is_scen;
  logic is_mc, is_mch, is_uc, is_uch;
  logic m_only, user, is_wr, cen_ok;
  logic we, cw;
  logic [63:0] cnt_rd, evt_rd, rd_full;
  logic [63:0] wr64, wv64, new64;
  logic [EW-1:0] ev_new;
  // bit 0 stands for "no event" so a zero selector never counts
  logic [NUM_EVENTS:0] ev_ext;

  assign idx     = addr[4:0];
  assign blk     = addr[11:5];
  assign is_inh  = addr == 12'h320;
  assign is_evt  = blk == 7'h19 && idx >= 5'd3;
  assign is_mcen = addr == 12'h306;
  assign is_scen = addr == 12'h106;
  assign is_mc   = blk == 7'h58 && idx != 5'd1;
  assign is_mch  = RV32 && blk == 7'h5C && idx != 5'd1;
  assign is_uc   = blk == 7'h60;
  assign is_uch  = RV32 && blk == 7'h64;

  assign m_only   = is_inh | is_evt | is_mcen | is_mc | is_mch;
  assign user     = is_uc | is_uch;
  assign addr_hit = m_only | is_scen | user;
  assign is_wr    = csr_op inside {CsrRW, CsrRS, CsrRC};

  always_comb begin
    case (privilege_mode)
      2'd0:    cen_ok = mcen_q[idx] & scen_q[idx];
      2'd1:    cen_ok = mcen_q[idx];
      default: cen_ok = 1'b1;
    endcase
  end

  assign access_fault =
    (m_only && privilege_mode != 2'd3) ||
    (user && (is_wr || !cen_ok));

  // idx 1 is only reachable through the user window (time)
  always_comb begin
    cnt_rd = '0;
    evt_rd = '0;
    if (idx == 5'd0) cnt_rd = mcycle_q;
    else if (idx == 5'd1) cnt_rd = mtime;
    else if (idx == 5'd2) cnt_rd = minstret_q;
    for (int j = 0; j < HPM_COUNTERS; j++) begin
      if (idx == 5'(j + 3)) begin
        cnt_rd = 64'(hpm_q[j]);
        evt_rd = 64'(evt_q[j]);
      end
    end
  end

  always_comb begin
    rd_full = '0;
    unique case (1'b1)
      is_inh:          rd_full = {32'd0, inh_q};
      is_mcen:         rd_full = {32'd0, mcen_q};
      is_scen:         rd_full = {32'd0, scen_q};
      is_evt:          rd_full = evt_rd;
      is_mc, is_uc:    rd_full = RV32 ? {32'd0, cnt_rd[31:0]}
                                      : cnt_rd;
      is_mch, is_uch:  rd_full = {32'd0, cnt_rd[63:32]};
      default:         rd_full = '0;
    endcase
  end

  assign rd_data = rd_full[DATA_SIZE-1:0];
  assign wr64    = 64'(wr_data);

  always_comb begin
    case (csr_op)
      CsrRS:   wv64 = rd_full | wr64;
      CsrRC:   wv64 = rd_full & ~wr64;
      default: wv64 = wr64;
    endcase
  end

  assign we = is_wr & addr_hit & ~access_fault & ~trap;
  assign cw = we & (is_mc | is_mch);

  // a half write keeps the other 32 bits of the counter
  assign new64 = is_mch ? {wv64[31:0], cnt_rd[31:0]}
               : RV32   ? {cnt_rd[63:32], wv64[31:0]}
                        : wv64;

  assign ev_new = (wv64 > 64'(NUM_EVENTS)) ? '0 : wv64[EW-1:0];
  assign ev_ext = {hpm_event, 1'b0};

  always_comb begin
    mcycle_d   = mcycle_q + {63'd0, ~inh_q[0]};
    minstret_d = minstret_q + {63'd0, instret_pulse & ~inh_q[2]};
    if (cw && idx == 5'd0) mcycle_d = new64;
    if (cw && idx == 5'd2) minstret_d = new64;
    hpm_d = hpm_q;
    evt_d = evt_q;
    for (int j = 0; j < HPM_COUNTERS; j++) begin
      hpm_d[j] = hpm_q[j] +
        HPM_WIDTH'(ev_ext[evt_q[j]] & ~inh_q[5'(j + 3)]);
      if (cw && idx == 5'(j + 3))
        hpm_d[j] = new64[HPM_WIDTH-1:0];
      if (we && is_evt && idx == 5'(j + 3))
        evt_d[j] = ev_new;
    end
    inh_d  = (we && is_inh)  ? wv64[31:0] & INH_MASK : inh_q;
    mcen_d = (we && is_mcen) ? wv64[31:0] & EN_MASK  : mcen_q;
    scen_d = (we && is_scen) ? wv64[31:0] & EN_MASK  : scen_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      hpm_q      <= '{default: '0};
      evt_q      <= '{default: '0};
      inh_q      <= '0;
      mcen_q     <= '0;
      scen_q     <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      hpm_q      <= hpm_d;
      evt_q      <= evt_d;
      inh_q      <= inh_d;
      mcen_q     <= mcen_d;
      scen_q     <= scen_d;
    end
  end

endmodule

// File: tb/tb_csr_counters.sv
// tb_csr_counters: directed checks of csr_counters, RV64 with 8-bit HPM
// counters and RV32 with defaults, both driven from the same stimulus.
module tb_csr_counters;
  import csr_counters_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  cs_op_t      csr_op = CsrRd;
  logic        trap = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [63:0] wr_data = '0;
  logic [1:0]  privilege_mode = 2'd3;
  logic        instret_pulse = 1'b0;
  logic [7:0]  hpm_event = '0;
  logic [63:0] mtime = 64'h1234_5678_9ABC_DEF0;

  logic [63:0] rd64;
  logic        hit64, flt64;
  logic [31:0] rd32;
  logic        hit32, flt32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  csr_counters #(
    .DATA_SIZE(64), .HPM_COUNTERS(4), .HPM_WIDTH(8), .NUM_EVENTS(8)
  ) dut64 (
    .clock(clock), .reset(reset), .csr_op(csr_op), .trap(trap),
    .addr(addr), .wr_data(wr_data), .privilege_mode(privilege_mode),
    .instret_pulse(instret_pulse), .hpm_event(hpm_event),
    .mtime(mtime), .rd_data(rd64), .addr_hit(hit64),
    .access_fault(flt64)
  );

  csr_counters #(
    .DATA_SIZE(32), .HPM_COUNTERS(4), .HPM_WIDTH(40), .NUM_EVENTS(8)
  ) dut32 (
    .clock(clock), .reset(reset), .csr_op(csr_op), .trap(trap),
    .addr(addr), .wr_data(wr_data[31:0]),
    .privilege_mode(privilege_mode),
    .instret_pulse(instret_pulse), .hpm_event(hpm_event),
    .mtime(mtime), .rd_data(rd32), .addr_hit(hit32),
    .access_fault(flt32)
  );

  // one clock cycle: inputs applied at the falling edge, sampled 1 later
  task automatic cyc(input cs_op_t op, input logic [11:0] a,
                     input logic [63:0] d, input logic tr = 1'b0,
                     input logic [1:0] p = 2'd3);
    @(negedge clock);
    csr_op = op; addr = a; wr_data = d;
    trap = tr; privilege_mode = p;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b0;
    csr_op = CsrRd; addr = 12'h320; #1;
    n_cmp++; if (rd64 !== 64'd0) begin n_bad++; $display("FAIL rst_inh: got %0h want 0", rd64); end
    addr = 12'hB03; #1;
    n_cmp++; if (rd64 !== 64'd0) begin n_bad++; $display("FAIL rst_hpm3: got %0h want 0", rd64); end
    addr = 12'hB00; #1;
    n_cmp++; if (hit64 !== 1'b1) begin n_bad++; $display("FAIL rst_hit: got %0b want 1", hit64); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc(CsrRd, 12'hB00, '0);
      n_cmp++; if (rd64 !== 64'(k)) begin n_bad++; $display("FAIL rst_cyc64 k=%0d: got %0h want %0h", k, rd64, k); end
      n_cmp++; if (rd32 !== 32'(k)) begin n_bad++; $display("FAIL rst_cyc32 k=%0d: got %0h want %0h", k, rd32, k); end
    end
  endtask

  task automatic test_inhibit;
    for (int k = 0; k < 15; k++) cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'd18) begin n_bad++; $display("FAIL inh_pre: got %0h want 12", rd64); end
    cyc(CsrRW, 12'h320, 64'h1);
    for (int k = 0; k < 4; k++) begin
      cyc(CsrRd, 12'hB00, '0);
      n_cmp++; if (rd64 !== 64'd20) begin n_bad++; $display("FAIL inh_hold k=%0d: got %0h want 14", k, rd64); end
    end
    cyc(CsrRd, 12'hB02, '0);
    instret_pulse = 1'b1;
    n_cmp++; if (rd64 !== 64'd0) begin n_bad++; $display("FAIL instret0: got %0h want 0", rd64); end
    cyc(CsrRd, 12'hB02, '0);
    cyc(CsrRd, 12'hB02, '0);
    cyc(CsrRd, 12'hB02, '0);
    instret_pulse = 1'b0;
    n_cmp++; if (rd64 !== 64'd3) begin n_bad++; $display("FAIL instret3: got %0h want 3", rd64); end
  endtask

  task automatic test_hpm;
    cyc(CsrRW, 12'hB03, 64'hFE);
    cyc(CsrRW, 12'h323, 64'h1);
    cyc(CsrRd, 12'hB03, '0);
    hpm_event = 8'h01;
    n_cmp++; if (rd64 !== 64'hFE) begin n_bad++; $display("FAIL hpm_fe: got %0h want fe", rd64); end
    cyc(CsrRd, 12'hB03, '0);
    n_cmp++; if (rd64 !== 64'hFF) begin n_bad++; $display("FAIL hpm_ff: got %0h want ff", rd64); end
    cyc(CsrRd, 12'hB03, '0);
    n_cmp++; if (rd64 !== 64'h00) begin n_bad++; $display("FAIL hpm_wrap: got %0h want 0", rd64); end
    n_cmp++; if (rd32 !== 32'h100) begin n_bad++; $display("FAIL hpm40_carry: got %0h want 100", rd32); end
    cyc(CsrRd, 12'hB03, '0);
    hpm_event = 8'h00;
    n_cmp++; if (rd64 !== 64'h01) begin n_bad++; $display("FAIL hpm_01: got %0h want 1", rd64); end
    cyc(CsrRW, 12'hB03, 64'hFFFF_FF12);
    cyc(CsrRd, 12'hB03, '0);
    n_cmp++; if (rd64 !== 64'h12) begin n_bad++; $display("FAIL hpm_trunc: got %0h want 12", rd64); end
    cyc(CsrRW, 12'h323, 64'h1FF);
    cyc(CsrRd, 12'h323, '0);
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL evt_big: got %0h want 0", rd64); end
    cyc(CsrRW, 12'h323, 64'h8);
    cyc(CsrRd, 12'h323, '0);
    n_cmp++; if (rd64 !== 64'h8) begin n_bad++; $display("FAIL evt_max: got %0h want 8", rd64); end
    cyc(CsrRW, 12'h323, 64'h9);
    cyc(CsrRd, 12'h323, '0);
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL evt_over: got %0h want 0", rd64); end
    cyc(CsrRW, 12'hB07, 64'h55);
    cyc(CsrRd, 12'hB07, '0);
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL unimpl_rd: got %0h want 0", rd64); end
    n_cmp++; if (hit64 !== 1'b1) begin n_bad++; $display("FAIL unimpl_hit: got %0b want 1", hit64); end
    cyc(CsrRd, 12'hB01, '0);
    n_cmp++; if (hit64 !== 1'b0) begin n_bad++; $display("FAIL b01_hit: got %0b want 0", hit64); end
  endtask

  task automatic test_priv;
    cyc(CsrRW, 12'h306, 64'h1);
    cyc(CsrRW, 12'h106, 64'h0);
    cyc(CsrRd, 12'hC00, '0, 1'b0, 2'd0);
    n_cmp++; if (flt64 !== 1'b1) begin n_bad++; $display("FAIL u_nos: got %0b want 1", flt64); end
    cyc(CsrRd, 12'hC00, '0, 1'b0, 2'd1);
    n_cmp++; if (flt64 !== 1'b0) begin n_bad++; $display("FAIL s_ok: got %0b want 0", flt64); end
    cyc(CsrRW, 12'h106, 64'h1);
    cyc(CsrRd, 12'hC00, '0, 1'b0, 2'd0);
    n_cmp++; if (flt64 !== 1'b0) begin n_bad++; $display("FAIL u_ok: got %0b want 0", flt64); end
    n_cmp++; if (rd64 !== 64'd20) begin n_bad++; $display("FAIL u_cyc: got %0h want 14", rd64); end
    cyc(CsrRd, 12'hC02, '0, 1'b0, 2'd0);
    n_cmp++; if (flt64 !== 1'b1) begin n_bad++; $display("FAIL u_ins: got %0b want 1", flt64); end
    cyc(CsrRd, 12'hB00, '0, 1'b0, 2'd0);
    n_cmp++; if (flt64 !== 1'b1) begin n_bad++; $display("FAIL u_mcyc: got %0b want 1", flt64); end
    cyc(CsrRW, 12'hC00, 64'h55);
    n_cmp++; if (flt64 !== 1'b1) begin n_bad++; $display("FAIL m_wr_c00: got %0b want 1", flt64); end
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'd20) begin n_bad++; $display("FAIL c00_nowr: got %0h want 14", rd64); end
    cyc(CsrRd, 12'hC01, '0);
    n_cmp++; if (rd64 !== 64'h1234_5678_9ABC_DEF0) begin n_bad++; $display("FAIL time64: got %0h want 123456789abcdef0", rd64); end
    n_cmp++; if (rd32 !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL time32: got %0h want 9abcdef0", rd32); end
    addr = 12'hC81; #1;
    n_cmp++; if (rd32 !== 32'h1234_5678) begin n_bad++; $display("FAIL timeh32: got %0h want 12345678", rd32); end
    n_cmp++; if (hit64 !== 1'b0) begin n_bad++; $display("FAIL c81_hit64: got %0b want 0", hit64); end
  endtask

  task automatic test_write_trap;
    cyc(CsrRW, 12'h320, 64'h0);
    cyc(CsrRW, 12'hB00, 64'h100);
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'h100) begin n_bad++; $display("FAIL wr_100: got %0h want 100", rd64); end
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'h101) begin n_bad++; $display("FAIL wr_101: got %0h want 101", rd64); end
    cyc(CsrRW, 12'hB00, 64'h100, 1'b1);
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'h103) begin n_bad++; $display("FAIL trap_blk: got %0h want 103", rd64); end
    cyc(CsrRS, 12'hB00, 64'h3);
    n_cmp++; if (rd64 !== 64'h104) begin n_bad++; $display("FAIL rs_old: got %0h want 104", rd64); end
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'h107) begin n_bad++; $display("FAIL rs_new: got %0h want 107", rd64); end
  endtask

  task automatic test_back_to_back;
    cyc(CsrRW, 12'hB00, 64'h10);
    cyc(CsrRW, 12'hB00, 64'h20);
    n_cmp++; if (rd64 !== 64'h10) begin n_bad++; $display("FAIL b2b_1: got %0h want 10", rd64); end
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd64 !== 64'h20) begin n_bad++; $display("FAIL b2b_2: got %0h want 20", rd64); end
  endtask

  task automatic test_masks;
    cyc(CsrRW, 12'h320, 64'hFFFF_FFFF);
    cyc(CsrRd, 12'h320, '0);
    n_cmp++; if (rd64 !== 64'h7D) begin n_bad++; $display("FAIL inh_mask: got %0h want 7d", rd64); end
    cyc(CsrRC, 12'h320, 64'h7C);
    cyc(CsrRd, 12'h320, '0);
    n_cmp++; if (rd64 !== 64'h1) begin n_bad++; $display("FAIL inh_rc: got %0h want 1", rd64); end
    cyc(CsrRW, 12'h306, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(CsrRd, 12'h306, '0);
    n_cmp++; if (rd64 !== 64'h7F) begin n_bad++; $display("FAIL mcen_mask: got %0h want 7f", rd64); end
    cyc(CsrRW, 12'h320, 64'h0);
  endtask

  task automatic test_rv32;
    cyc(CsrRW, 12'hB80, 64'h1);
    cyc(CsrRW, 12'hB00, 64'hFFFF_FFFF);
    cyc(CsrRd, 12'hB00, '0);
    n_cmp++; if (rd32 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rv32_lo1: got %0h want ffffffff", rd32); end
    cyc(CsrRd, 12'hB80, '0);
    n_cmp++; if (rd32 !== 32'h2) begin n_bad++; $display("FAIL rv32_hi: got %0h want 2", rd32); end
    n_cmp++; if (hit64 !== 1'b0) begin n_bad++; $display("FAIL b80_hit64: got %0b want 0", hit64); end
    n_cmp++; if (hit32 !== 1'b1) begin n_bad++; $display("FAIL b80_hit32: got %0b want 1", hit32); end
    addr = 12'hB00; #1;
    n_cmp++; if (rd32 !== 32'h0) begin n_bad++; $display("FAIL rv32_lo: got %0h want 0", rd32); end
    n_cmp++; if (rd64 !== 64'h1_0000_0000) begin n_bad++; $display("FAIL rv64_carry: got %0h want 100000000", rd64); end
  endtask

  task automatic test_reset_mid;
    cyc(CsrRW, 12'hB00, 64'h55);
    reset = 1'b1;
    cyc(CsrRd, 12'hB00, '0);
    reset = 1'b0;
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL mid_cyc: got %0h want 0", rd64); end
    addr = 12'h306; #1;
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL mid_mcen: got %0h want 0", rd64); end
    addr = 12'hB03; #1;
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL mid_hpm: got %0h want 0", rd64); end
    addr = 12'hB80; #1;
    n_cmp++; if (rd32 !== 32'h0) begin n_bad++; $display("FAIL mid_hi32: got %0h want 0", rd32); end
  endtask

  initial begin
    test_reset;
    test_inhibit;
    test_hpm;
    test_priv;
    test_write_trap;
    test_back_to_back;
    test_masks;
    test_rv32;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_counters.md
# csr_counters

Parametrised counter/timer CSR unit that sits beside the core CSR file and owns the machine and user counter address spaces. It implements `mcycle`, `minstret`, a configurable bank of `mhpmcounter`/`mhpmevent` pairs, `mcountinhibit`, `mcounteren`/`scounteren`, and their user read-only shadows. It supports RV32 (high-half CSRs) and RV64, and does its own privilege and enable checks. The core ORs `rd_data` and `access_fault` into the CSR read path and exception logic.

## Interface
- `DATA_SIZE`, 64: XLEN; only 32 and 64 are legal.
- `HPM_COUNTERS`, 4: number of implemented `mhpmcounter3..`; range 0..29.
- `HPM_WIDTH`, 40: implemented bits per HPM counter; range 1..64.
- `NUM_EVENTS`, 8: width of the event bus; range 1..255.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `csr_op`  in  `cs_op_t`  `CsrRW`/`CsrRS`/`CsrRC` are writes; every other value is read-only.
- `trap`  in  1  a trap is taken this cycle; all CSR writes are blocked.
- `addr`  in  12  CSR address.
- `wr_data`  in  `DATA_SIZE`  source operand.
- `privilege_mode`  in  2  current privilege (U=0, S=1, M=3).
- `instret_pulse`  in  1  one instruction retires this cycle; the core drives it low for trapping instructions.
- `hpm_event`  in  `NUM_EVENTS`  per-cycle event strobes.
- `mtime`  in  64  platform timer value, read through `time`/`timeh`.
- `rd_data`  out  `DATA_SIZE`  combinational read value; 0 when `addr_hit`=0.
- `addr_hit`  out  1  `addr` belongs to this block.
- `access_fault`  out  1  illegal access; valid only when `addr_hit`=1.

## Operation
- Address map:
  - `mcountinhibit` 0x320.
  - `mhpmevent3..31` 0x323–0x33F.
  - `mcounteren` 0x306; `scounteren` 0x106.
  - `mcycle` 0xB00; `minstret` 0xB02; `mhpmcounter3..31` 0xB03–0xB1F.
  - User shadows 0xC00–0xC1F (0xC01 = `time`).
  - RV32 only: high halves at 0xB80–0xB9F and 0xC80–0xC9F. When `DATA_SIZE`=64 these addresses give `addr_hit`=0.
  - 0xB01 and 0xB81 are not hits.
- Write data: `CsrRW` writes `wr_data`. `CsrRS` writes `rd_data|wr_data`. `CsrRC` writes `rd_data&~wr_data`.
- Write commit condition: write op & `addr_hit` & !`access_fault` & !`trap`.
- `access_fault` conditions:
  - 0x3xx or 0xBxx address with `privilege_mode`≠M.
  - Any write op to 0xCxx.
  - Read of 0xCxx/0xC8x, counter index i=`addr[4:0]`: in S, `mcounteren[i]`=0; in U, `mcounteren[i]`&`scounteren[i]`=0.
- `mcountinhibit`, `mcounteren`, `scounteren`:
  - Writable bits: 0 and 2 (`mcounteren`/`scounteren` also bit 1), plus 3..3+`HPM_COUNTERS`-1.
  - All other bits read 0.
  - `mcountinhibit` bit 1 is hard-wired to 0.
- `mhpmeventN`:
  - Value k in 1..`NUM_EVENTS` counts `hpm_event[k-1]`; 0 counts nothing.
  - A written value >`NUM_EVENTS` stores 0.
  - Stored width is `clog2(NUM_EVENTS+1)`; upper bits read 0.
- Increment rules:
  - `mcycle` +1 each cycle unless inhibit bit 0 is set.
  - `minstret` +1 on `instret_pulse` unless inhibit bit 2 is set.
  - HPM counter N +1 when its selected event is high and inhibit bit N is clear.
- Counter widths and wrap:
  - `mcycle` and `minstret` are 64-bit and wrap to 0.
  - HPM counters wrap at 2^`HPM_WIDTH`.
  - Reads zero-extend HPM counters; writes truncate.
- Unimplemented counters (indices ≥3+`HPM_COUNTERS`) and their events: `addr_hit`=1, read 0, writes ignored.
- RV32 half writes: a write to either half changes only those 32 bits.
- Write/increment collision: a committed write to any half of a counter suppresses that counter's increment in the same cycle.
- `time`/`timeh` return `mtime`; they are never written.

## Timing
- Reset: takes priority over writes and increments. Every counter and CSR becomes 0, so `rd_data`=0 for all addresses on the cycle after the reset edge.
- Reads are combinational and return the register value before this cycle's update.
- Committed writes are visible on the next cycle.
- A counter write of X reads X on the next cycle and X+1 on the following cycle if still counting.
- Writes to `mcountinhibit` or `mhpmevent` take effect from the next cycle; the current cycle uses the old value.
- `trap` does not stop counting.
- Reset asserted mid-sequence clears everything; no pending state survives.

## Test plan
- Reset held 2 cycles, then released; with no inhibit, read 0xB00 in cycle k after release → k (0,1,2,…).
- Write `mcountinhibit`=0x1 in M at count 20 → `mcycle` reads 20 from then on. With `instret_pulse`=1 for 3 cycles, `minstret` advances by 3.
- `HPM_WIDTH`=8: write `mhpmcounter3`=0xFE and `mhpmevent3`=1, then hold `hpm_event[0]`=1 → reads 0xFE, 0xFF, 0x00, 0x01. Bits ≥8 stay 0. Writing `mhpmevent3`=0x1FF reads back 0.
- With U mode, `mcounteren`=0x1, `scounteren`=0: read 0xC00 → `access_fault`=1. Set `scounteren`=0x1 → fault 0 and `rd_data`=`mcycle`. `CsrRW` 0xC00 in M → fault, no write.
- `CsrRW` `mcycle`=0x100 → next read 0x100, then 0x101. The same op with `trap`=1 → no write, counting continues. `CsrRS` 0x3 on `mcycle`=0x104 → next read 0x107.
- `DATA_SIZE`=32: write `mcycleh`=0x1, then `mcycle`=0xFFFFFFFF → two cycles later `mcycleh`=0x2 and `mcycle`=0x0. In RV64, 0xB80 gives `addr_hit`=0.
